uart_tx_unit: RTL and testbench

//  UART transmit peripheral directly downstream of the CPU data-bus address decoder.
//  - Consumes the decoder's register strobes:
//    - WEId: TX data write, addr 60.
//    - WEIc: control write, addr 61.
//    - WEIs: status read, addr 62.
//  - Holds a one-entry TX holding register feeding a shift register; serialises 8N1 frames on tx.
//  - Supplies read data to the CPU read-back mux; the CPU selects it when Rd_sel=1.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 20 ++
 rtl/uart_tx_unit.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit block: register map, bit positions, FSM states.
package uart_pkg;
  localparam int UART_BASE = 60;

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_CTRL = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_RXD  = 2'd3;

  localparam int CTRL_EN_BIT  = 16;
  localparam int CTRL_PAR_BIT = 17;

  localparam int STAT_THRE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_OVR_BIT  = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: reloads at every bit start, pulses bit_done on a bit's last clk.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             bit_done
);
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (hold || cnt == '0) cnt <= div;
    else                        cnt <= cnt - 1'b1;
  end

  assign bit_done = !hold && (cnt == '0);
endmodule

// File: rtl/uart_tx_unit.sv
// UART 8N1 transmitter with one-entry holding register and CPU register interface.
// Optional parity bit when UART_TX_PARITY_EN is defined.
import uart_pkg::*;

module uart_tx_unit #(
  parameter int               DIV_W         = 16,
  parameter logic [DIV_W-1:0] CLK_DIV_RESET = DIV_W'(433)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WEId,
  input  logic        WEIc,
  input  logic        WEIs,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_irq
);
  tx_state_t        state, state_d;
  logic [2:0]       bit_idx, idx_d;
  logic [7:0]       shreg, hold_data;
  logic [DIV_W-1:0] ctrl_div, frame_div, baud_div;
  logic             hold_full, tx_en, ovr;
  logic             load, wr_ok, bit_done, tx_d;
  logic             unused_wdata;
`ifdef UART_TX_PARITY_EN
  logic             par_odd, frame_par;
`endif

  assign unused_wdata = ^wdata;

  // Reload at a frame boundary picks up the live divisor; mid-frame bits keep the latched one.
  assign baud_div = (state == IDLE || state == STOP) ? ctrl_div : frame_div;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (state == IDLE),
    .div     (baud_div),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d = state;
    idx_d   = bit_idx;
    load    = 1'b0;
    tx_d    = 1'b1;
    case (state)
      IDLE: if (hold_full && tx_en) begin
        load    = 1'b1;
        state_d = START;
      end
      START: if (bit_done) begin
        state_d = DATA;
        idx_d   = 3'd0;
      end
      DATA: if (bit_done) begin
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d = bit_idx + 3'd1;
        end
      end
      PARITY: if (bit_done) state_d = STOP;
      STOP: if (bit_done) begin
        if (hold_full && tx_en) begin
          load    = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the next state so the line changes exactly at bit boundaries.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^shreg ^ frame_par;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      frame_div <= CLK_DIV_RESET;
      tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      frame_par <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      bit_idx <= idx_d;
      tx      <= tx_d;
      if (load) begin
        shreg     <= hold_data;
        frame_div <= ctrl_div;
`ifdef UART_TX_PARITY_EN
        frame_par <= par_odd;
`endif
      end
    end
  end

  // A write landing on the same edge the shifter drains the holding register is accepted.
  assign wr_ok = WEId && (!hold_full || load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      ovr       <= 1'b0;
      ctrl_div  <= CLK_DIV_RESET;
      tx_en     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_odd   <= 1'b0;
`endif
    end else begin
      if (wr_ok) begin
        hold_full <= 1'b1;
        hold_data <= wdata[7:0];
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (WEId && !wr_ok) ovr <= 1'b1;
      else if (WEIs)      ovr <= 1'b0;
      if (WEIc) begin
        ctrl_div <= wdata[DIV_W-1:0];
        tx_en    <= wdata[CTRL_EN_BIT];
`ifdef UART_TX_PARITY_EN
        par_odd  <= wdata[CTRL_PAR_BIT];
`endif
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      OFF_DATA: rdata[7:0] = hold_data;
      OFF_CTRL: begin
        rdata[DIV_W-1:0]   = ctrl_div;
        rdata[CTRL_EN_BIT] = tx_en;
`ifdef UART_TX_PARITY_EN
        rdata[CTRL_PAR_BIT] = par_odd;
`endif
      end
      OFF_STAT: begin
        rdata[STAT_THRE_BIT] = !hold_full;
        rdata[STAT_BUSY_BIT] = (state != IDLE);
        rdata[STAT_OVR_BIT]  = ovr;
      end
      OFF_RXD: rdata = 32'h0;
    endcase
  end

  assign tx_irq = !hold_full && tx_en;
endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx_unit;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        WEId = 1'b0, WEIc = 1'b0, WEIs = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx, tx_irq;

  always #5 clk = ~clk;

  uart_tx_unit dut (
    .clk(clk), .rst_n(rst_n), .WEId(WEId), .WEIc(WEIc), .WEIs(WEIs),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .tx_irq(tx_irq)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus the current frame as (byte, divisor, position).
  logic        m_full, m_busy, m_ovr, m_en, m_par, m_fpar, m_fin, m_go;
  logic [7:0]  m_data, m_fbyte;
  logic [15:0] m_div, m_fdiv;
  int          m_pos, m_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 0; m_busy = 0; m_ovr = 0; m_en = 0; m_par = 0; m_fpar = 0;
      m_data = 0; m_fbyte = 0; m_div = 16'd433; m_fdiv = 16'd433; m_pos = 0;
    end else begin
      m_len = NB * (int'(m_fdiv) + 1);
      m_fin = m_busy && (m_pos == m_len - 1);
      m_go  = (!m_busy || m_fin) && m_en && m_full;
      if (WEId && m_full && !m_go) m_ovr = 1;
      else if (WEIs)               m_ovr = 0;
      if (m_go) begin
        m_fbyte = m_data; m_fdiv = m_div; m_fpar = m_par; m_pos = 0; m_busy = 1;
      end else if (m_fin) m_busy = 0;
      else if (m_busy)    m_pos++;
      if (WEId && (!m_full || m_go)) begin m_full = 1; m_data = wdata[7:0]; end
      else if (m_go) m_full = 0;
      if (WEIc) begin
        m_div = wdata[15:0]; m_en = wdata[16];
`ifdef UART_TX_PARITY_EN
        m_par = wdata[17];
`endif
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / (int'(m_fdiv) + 1);
    if (k == 0) return 1'b0;
    if (k <= 8) return m_fbyte[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^m_fbyte ^ m_fpar;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      2'd0: r[7:0] = m_data;
      2'd1: begin
        r[15:0] = m_div; r[16] = m_en;
`ifdef UART_TX_PARITY_EN
        r[17] = m_par;
`endif
      end
      2'd2: r[2:0] = {m_ovr, m_busy, !m_full};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    check("tx", {31'h0, tx}, {31'h0, exp_tx()});
    check("tx_irq", {31'h0, tx_irq}, {31'h0, !m_full && m_en});
    check("rdata", rdata, exp_rdata(addr));
  end

  task automatic step(input logic d, input logic c, input logic s,
                      input logic [1:0] a, input logic [31:0] w);
    @(negedge clk);
    WEId = d; WEIc = c; WEIs = s; addr = a; wdata = w;
  endtask

  logic [NB-1:0] fa5, f55, f0f;

  initial begin
`ifdef UART_TX_PARITY_EN
    fa5 = 11'b1_0_10100101_0; f55 = 11'b1_0_01010101_0; f0f = 11'b1_0_00001111_0;
`else
    fa5 = 10'b1_10100101_0;   f55 = 10'b1_01010101_0;   f0f = 10'b1_00001111_0;
`endif
    // Reset values
    repeat (3) @(negedge clk);
    addr = 2'd2; #1 check("rst_stat", rdata, 32'h1);
    addr = 2'd1; #1 check("rst_ctrl", rdata, 32'd433);
    check("rst_tx", {31'h0, tx}, 32'h1);
    @(negedge clk); rst_n = 1'b1;

    // Single byte 0xA5 at div=3
    step(0, 1, 0, 2'd2, 32'h10003);
    step(1, 0, 0, 2'd2, 32'hA5);
    step(0, 0, 0, 2'd2, 32'h0);
    for (int k = 0; k < NB * 4; k++) begin
      step(0, 0, 0, 2'd2, 32'h0);
      #1 check("a5_bit", {31'h0, tx}, {31'h0, fa5[k/4]});
      check("a5_busy", {31'h0, rdata[1]}, 32'h1);
    end

    // Back-to-back frames with no idle gap
    step(1, 0, 0, 2'd2, 32'h55);
    step(0, 0, 0, 2'd2, 32'h0);
    for (int k = 0; k < 2 * NB * 4; k++) begin
      step(k == 0, 0, 0, 2'd2, 32'h0F);
      #1 check("b2b_bit", {31'h0, tx}, {31'h0, (k < NB * 4) ? f55[k/4] : f0f[k/4 - NB]});
      check("b2b_thre", {31'h0, rdata[0]}, {31'h0, (k == 0 || k >= NB * 4)});
    end

    // Overrun with transmitter disabled, then status-read clear
    step(0, 1, 0, 2'd0, 32'h00003);
    step(1, 0, 0, 2'd0, 32'h11);
    step(1, 0, 0, 2'd0, 32'h22);
    step(0, 0, 0, 2'd0, 32'h0);
    #1 check("ovr_hold", rdata, 32'h11);
    addr = 2'd2; #1 check("ovr_stat", rdata, 32'h4);
    step(0, 0, 1, 2'd2, 32'h0);
    step(0, 0, 0, 2'd2, 32'h0);
    #1 check("ovr_clr", rdata, 32'h0);

    // Enable, write on the load edge, then change divisor mid-frame
    step(0, 1, 0, 2'd2, 32'h10003);
    step(1, 0, 0, 2'd2, 32'h33);
    repeat (6) step(0, 0, 0, 2'd2, 32'h0);
    step(0, 1, 0, 2'd1, 32'h10007);
    repeat (140) step(0, 0, 0, 2'($urandom_range(0, 3)), 32'h0);

    // Async reset during DATA
    step(0, 1, 0, 2'd2, 32'h10003);
    step(1, 0, 0, 2'd2, 32'h5A);
    step(0, 0, 0, 2'd2, 32'h0);
    step(1, 0, 0, 2'd2, 32'hC3);
    repeat (4) step(0, 0, 0, 2'd2, 32'h0);
    #1 check("pre_rst_tx", {31'h0, tx}, 32'h0);
    #1 rst_n = 1'b0;
    #1 check("rst_tx_now", {31'h0, tx}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_stat", rdata, 32'h1);

`ifdef UART_TX_PARITY_EN
    step(0, 1, 0, 2'd2, 32'h30001);
    step(1, 0, 0, 2'd2, 32'h03);
    step(0, 0, 0, 2'd2, 32'h0);
    for (int k = 0; k < 2 * NB; k++) begin
      step(0, 0, 0, 2'd2, 32'h0);
      if (k == 18) begin
        #1 check("par_bit", {31'h0, tx}, 32'h1);
      end
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] w;
      r = $urandom_range(0, 99);
      w = $urandom;
      if (r >= 20 && r < 23) begin
        w[15:0] = 16'($urandom_range(0, 3));
        w[16]   = ($urandom_range(0, 4) != 0);
      end
      step(r < 20, r >= 20 && r < 23, $urandom_range(0, 19) == 0,
           2'($urandom_range(0, 3)), w);
    end
    step(0, 0, 0, 2'd2, 32'h0);
    step(0, 0, 0, 2'd2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
